// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine with lane steering, wait-state handshake and load extension
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_write_m,
    input  logic [1:0]               result_src_m,
    input  logic [2:0]               funct3_m,
    input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
    input  logic [DATA_WIDTH-1:0]    write_data_m,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [3:0]               dmem_be,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_ack,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic                     stall_m,
    output logic                     misaligned_m
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic                    is_mem;
    logic                    access;
    logic [DATA_WIDTH-1:0]   lane;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Access qualification, lane steering and handshake outputs
    always_comb begin
        is_mem       = mem_write_m | (result_src_m == 2'b01);
        misaligned_m = is_mem & ((funct3_m[1:0] == 2'b01 & alu_result_m[0])
                               | (funct3_m[1:0] == 2'b10 & alu_result_m[1:0] != 2'b00)
                               | funct3_m == 3'b011 | funct3_m[2:1] == 2'b11);
        access       = is_mem & ~misaligned_m;
        dmem_req     = (state == IDLE & access) | state == WAIT;
        stall_m      = dmem_req;
        dmem_we      = mem_write_m;
        dmem_addr    = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
        dmem_be      = funct3_m[1:0] == 2'b00 ? 4'b0001 << alu_result_m[1:0]
                     : funct3_m[1:0] == 2'b01 ? 4'b0011 << {alu_result_m[1], 1'b0}
                     : 4'b1111;
        dmem_wdata   = funct3_m[1:0] == 2'b00 ? {4{write_data_m[7:0]}}
                     : funct3_m[1:0] == 2'b01 ? {2{write_data_m[15:0]}}
                     : write_data_m;
        lane         = dmem_rdata >> {alu_result_m[1:0], 3'b000};
        load_ext     = funct3_m[1:0] == 2'b00 ? {{24{~funct3_m[2] & lane[7]}}, lane[7:0]}
                     : funct3_m[1:0] == 2'b01 ? {{16{~funct3_m[2] & lane[15]}}, lane[15:0]}
                     : dmem_rdata;
    end

    // Handshake FSM; load result captured only on an acknowledged read request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            read_data_m <= '0;
        end else begin
            if (dmem_req && dmem_ack && !dmem_we)
                read_data_m <= load_ext;
            case (state)
                IDLE:    state <= !access ? IDLE : dmem_ack ? DONE : WAIT;
                WAIT:    state <= dmem_ack ? DONE : WAIT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized transaction-level check of mem_access_unit against a behavioural model
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] read_data_m;
    logic        stall_m;
    logic        misaligned_m;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .read_data_m(read_data_m), .stall_m(stall_m), .misaligned_m(misaligned_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic bit m_mis(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a);
        return (st || ld) && (f3 == 3 || f3 >= 6 || (a % sz(f3)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << sz(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int    n = 8 * sz(f3);
        longint v = (longint'(rd) >> (8 * (a % 4))) & ((longint'(1) << n) - 1);
        if (!f3[2] && n < 32 && v >= (longint'(1) << (n - 1))) v -= longint'(1) << n;
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        mem_write_m  = 1'b0;
        result_src_m = 2'b00;
    endtask

    task automatic do_op(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int nw);
        bit mis = m_mis(st, ld, f3, a);
        mem_write_m  = st;
        result_src_m = ld ? 2'b01 : 2'(($urandom % 2) * 2);
        funct3_m     = f3;
        alu_result_m = a;
        write_data_m = wd;
        if (mis || !(st || ld)) begin
            dmem_ack   = 1'($urandom % 2);
            dmem_rdata = $urandom;
            #1;
            chk("mis_flag", 32'(misaligned_m), 32'(mis));
            chk("noacc_req", 32'(dmem_req), 0);
            chk("noacc_stall", 32'(stall_m), 0);
            @(posedge clk); #1;
            chk("noacc_rd", read_data_m, model_rd);
            idle_inputs();
            dmem_ack = 1'b0;
            return;
        end
        for (int c = 0; c <= nw; c++) begin
            dmem_ack   = (c == nw);
            dmem_rdata = (c == nw) ? rd : $urandom;
            #1;
            chk("req", 32'(dmem_req), 1);
            chk("stall", 32'(stall_m), 1);
            chk("mis", 32'(misaligned_m), 0);
            chk("we", 32'(dmem_we), 32'(st));
            chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("be", 32'(dmem_be), 32'(m_be(f3, a)));
            if (st) chk("wdata", dmem_wdata, m_wdata(f3, wd));
            @(posedge clk); #1;
        end
        if (ld && !st) model_rd = m_load(f3, a, rd);
        idle_inputs();
        dmem_ack = 1'($urandom % 2);
        #1;
        chk("done_req", 32'(dmem_req), 0);
        chk("done_stall", 32'(stall_m), 0);
        chk("done_rd", read_data_m, model_rd);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        idle_inputs();
        funct3_m = 3'd0; alu_result_m = '0; write_data_m = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        model_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", read_data_m, 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stall_m), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 1, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0);
        chk("lw_val", read_data_m, 32'hDEADBEEF);
        do_op(0, 1, 3'd0, 32'h103, 0, 32'h80FF_0000, 0);
        chk("lb_val", read_data_m, 32'hFFFF_FF80);
        do_op(0, 1, 3'd4, 32'h103, 0, 32'h80FF_0000, 1);
        chk("lbu_val", read_data_m, 32'h0000_0080);
        do_op(0, 1, 3'd1, 32'h102, 0, 32'h80FF_0000, 0);
        chk("lh_val", read_data_m, 32'hFFFF_80FF);
        do_op(1, 0, 3'd0, 32'h101, 32'h1234_56AB, 0, 0);
        do_op(1, 0, 3'd1, 32'h102, 32'h1234_56AB, 0, 0);
        do_op(1, 0, 3'd2, 32'h200, 32'hCAFE_F00D, 0, 3);
        chk("sw_keeps_rd", read_data_m, 32'hFFFF_80FF);
        do_op(0, 1, 3'd2, 32'h102, 0, 32'h1111_1111, 0);
        do_op(0, 1, 3'd1, 32'h101, 0, 32'h2222_2222, 0);
        do_op(1, 0, 3'd3, 32'h100, 32'h5, 0, 0);
        do_op(1, 1, 3'd2, 32'h104, 32'h7777_0001, 32'h3333_3333, 1);
        do_op(0, 0, 3'd2, 32'h108, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int r = $urandom % 10;
            bit st = (r < 4);
            bit ld = (r >= 3 && r < 9);
            logic [2:0] f3 = ($urandom % 8 == 0) ? 3'($urandom) : f3s[$urandom % 5];
            logic [31:0] a = $urandom;
            if ($urandom % 3 != 0) a = a & ~32'((sz(f3) - 1));
            do_op(st, ld, f3, a, $urandom, $urandom, $urandom_range(0, 3));
        end

        do_op(0, 1, 3'd2, 32'h300, 0, 32'hA5A5_5A5A, 0);
        mem_write_m = 1'b0; result_src_m = 2'b01; funct3_m = 3'd2; alu_result_m = 32'h304;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("wait_stall", 32'(stall_m), 1);
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_rd = '0;
        #1;
        chk("mid_rst_req", 32'(dmem_req), 0);
        chk("mid_rst_stall", 32'(stall_m), 0);
        chk("mid_rst_rd", read_data_m, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("spur_ack_rd", read_data_m, 0);
        chk("spur_ack_req", 32'(dmem_req), 0);
        dmem_ack = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs and performs the data-memory transaction for the instruction currently in M. It generates byte-lane enables and replicated store data, holds a request to a variable-latency data memory until acknowledged, and returns sign/zero-extended load data toward the MEM/WB register. It drives `stall_m` back to the pipeline-register enables (an enable of 1 holds a register) until the access completes.

## Interface
- `ADDRESS_WIDTH`, 32, address width; lane logic requires 32.
- `DATA_WIDTH`, 32, data width; lane logic requires 32.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `mem_write_m`  in  1  store in M.
- `result_src_m`  in  2  value 2'b01 marks a load.
- `funct3_m`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_result_m`  in  ADDRESS_WIDTH  byte address.
- `write_data_m`  in  DATA_WIDTH  store data, right-aligned.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 means write.
- `dmem_addr`  out  ADDRESS_WIDTH  word address, `{alu_result_m[31:2], 2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `dmem_ack`  in  1  completion; for reads, `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  DATA_WIDTH  read word.
- `read_data_m`  out  DATA_WIDTH  registered, extended load result.
- `stall_m`  out  1  holds the PC, F/D, D/E and E/M registers.
- `misaligned_m`  out  1  combinational access-fault flag.

## Operation
- access = (`mem_write_m` | `result_src_m`==2'b01) & !`misaligned_m`. If both the store and load qualifiers are set, the access is a store.
- `misaligned_m` = (load | store) & (H/HU with addr[0]=1 | W with addr[1:0]!=0 | funct3 in {011,110,111}). A faulting access issues no request and raises no stall.
- Store lanes:
  - B: `dmem_be` = 4'b0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - H: `dmem_be` = 4'b0011 << {addr[1],1'b0}; wdata = {2{wd[15:0]}}.
  - W: `dmem_be` = 4'b1111; wdata = wd.
- Loads drive `dmem_be` with the same lane pattern and `dmem_we`=0.
- Load extract selects the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- FSM states:
  - IDLE:
    - `dmem_req` = access.
    - On `dmem_ack` → DONE, capturing extended rdata.
    - Otherwise, if access → WAIT.
  - WAIT: `dmem_req`=1, with addr, be, we and wdata held from the inputs. The E/M register is stalled, so the inputs are stable. On `dmem_ack` → DONE, capturing rdata.
  - DONE: `dmem_req`=0 and `stall_m`=0; the pipeline advances on this edge. Next state is unconditionally IDLE.
- `stall_m` = (IDLE & access) | WAIT.
- `read_data_m` loads only on an acked load. Stores and faults leave it unchanged.
- `dmem_ack` received while `dmem_req`=0 is ignored.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state → IDLE; `read_data_m` → 0.
  - Combinational outputs then follow the IDLE equations.
  - This applies mid-WAIT as well: the request drops the cycle after reset and any later ack is ignored.
- Zero-wait memory (ack in the issue cycle): the access takes 2 cycles (issue, then DONE), with 1 stall cycle.
- N wait cycles: the access takes N+2 cycles, with N+1 stall cycles.
- `read_data_m` is valid from the DONE cycle and holds until the next acked load.
- A non-memory instruction in IDLE produces no request and no stall.
- Back-to-back accesses always pass through DONE, so there is one request-free cycle between them.

## Test plan
- LW at addr 0x100, ack in same cycle, rdata 0xDEADBEEF:
  - cycle 0: req=1, we=0, be=4'b1111, stall=1.
  - cycle 1: DONE, stall=0, `read_data_m`=0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF_0000 → 0xFFFFFF80 for LB and 0x00000080 for LBU. LH at 0x102 with the same rdata → 0xFFFF80FF.
- SB at 0x101 with wd=0x123456AB → be=4'b0010, wdata=0xABABABAB. SH at 0x102 with the same wd → be=4'b1100, wdata=0x56AB56AB.
- SW at 0x200, ack after 3 wait cycles → stall high 4 cycles; addr, be and wdata stable throughout; DONE follows; `read_data_m` unchanged.
- LW at 0x102, and LH at 0x101 → `misaligned_m`=1, req=0, stall=0. funct3=011 with `mem_write_m`=1 → `misaligned_m`=1.
- Reset during WAIT, then a spurious `dmem_ack` → state IDLE, req=0, stall=0, `read_data_m`=0 and unchanged by the ack.
